pre_decode_queue: RTL and testbench



---
 rtl/pre_decode_queue_pkg.sv | 40 ++++
 rtl/pre_decode_queue_fifo_mem.sv | 25 ++
 rtl/pre_decode_queue.sv | 134 +++++++++++++
 tb/tb_pre_decode_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pre_decode_queue_pkg.sv
// Shared definitions for the pre-decode instruction queue: category and state
// encodings, the stored entry layout and the static branch-prediction helpers.
package pre_decode_queue_pkg;

  localparam int DEFAULT_DEPTH = 8;

  localparam logic [1:0] CAT_OTHER = 2'b00;
  localparam logic [1:0] CAT_COND  = 2'b01;
  localparam logic [1:0] CAT_JUMP  = 2'b10;
  localparam logic [1:0] CAT_JIRL  = 2'b11;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    REDIR     = 2'd1,
    WAIT_JIRL = 2'd2
  } pdq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  category;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pdq_entry_t;

  localparam int ENTRY_W = $bits(pdq_entry_t);

  // Static prediction: unconditional jumps taken, conditional branches taken
  // only when backward (negative offset).
  function automatic logic predict_taken(input logic [1:0] cat, input logic [31:0] offset);
    return (cat == CAT_JUMP) || ((cat == CAT_COND) && offset[31]);
  endfunction

  function automatic logic [31:0] predict_target(input logic [31:0] pc,
                                                 input logic [31:0] offset,
                                                 input logic        taken);
    return taken ? (pc + offset) : (pc + 32'd4);
  endfunction

endpackage

// File: rtl/pre_decode_queue_fifo_mem.sv
// Entry storage for the pre-decode queue: one write port, asynchronous read
// at the (registered) read pointer. Contents are intentionally not reset.
module pdq_fifo_mem
  import pre_decode_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  pdq_entry_t       wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output pdq_entry_t       rd_data
);

  pdq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pre_decode_queue.sv
// Instruction queue between fetch and decode. Predicts branches at push time,
// emits one-cycle redirects and holds fetch while a JIRL target is unknown.
module pre_decode_queue
  import pre_decode_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        jirl_resolved,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic [1:0]  in_category,
  input  logic [31:0] in_pc_offset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [1:0]  out_category,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fetch_hold,
  output pdq_state_e  dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge when valid and ready
  // are both high; in_ready never depends on in_valid, out_valid never on out_ready.

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  pdq_state_e       state, state_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop;
  logic             push_taken;
  logic [31:0]      push_target;
  pdq_entry_t       wr_entry, head;

  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign push_taken  = predict_taken(in_category, in_pc_offset);
  assign push_target = predict_target(in_pc, in_pc_offset, push_taken);

  assign wr_entry.pc          = in_pc;
  assign wr_entry.inst        = in_inst;
  assign wr_entry.category    = in_category;
  assign wr_entry.pred_taken  = push_taken;
  assign wr_entry.pred_target = push_target;

  pdq_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_entry),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  // Pointers, occupancy and redirect target; flush clears queue bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      redirect_pc <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push && push_taken) redirect_pc <= push_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (push && push_taken)                   state_next = REDIR;
          else if (push && in_category == CAT_JIRL) state_next = WAIT_JIRL;
        end
        REDIR:     state_next = RUN;
        WAIT_JIRL: if (jirl_resolved) state_next = RUN;
        default:   state_next = RUN;
      endcase
    end
  end

  // in_ready is gated by rstn so it reads low throughout reset.
  always_comb begin
    in_ready       = 1'b0;
    redirect_valid = 1'b0;
    fetch_hold     = 1'b0;
    unique case (state)
      RUN:       in_ready = rstn && !flush && (count < FULL_COUNT);
      REDIR:     redirect_valid = 1'b1;
      WAIT_JIRL: fetch_hold = 1'b1;
      default:   ;
    endcase
  end

  assign out_valid       = (count != '0);
  assign out_pc          = head.pc;
  assign out_inst        = head.inst;
  assign out_category    = head.category;
  assign out_pred_taken  = head.pred_taken;
  assign out_pred_target = head.pred_target;
  assign dbg_state       = state;

endmodule

// File: tb/tb_pre_decode_queue.sv
// Directed bench for pre_decode_queue: scoreboard of expected head entries
// checked by a monitor on each pop, plus directed control-signal checks.
module tb_pre_decode_queue;
  import pre_decode_queue_pkg::*;

  localparam int W = 32 + 32 + 2 + 1 + 32;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0, jirl_resolved = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_inst = '0, in_pc_offset = '0;
  logic [1:0]  in_category = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_inst, out_pred_target;
  logic [1:0]  out_category;
  logic        out_pred_taken;
  logic        redirect_valid, fetch_hold;
  logic [31:0] redirect_pc;
  pdq_state_e  dbg_state;

  pre_decode_queue dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush           (flush),
    .jirl_resolved   (jirl_resolved),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_inst         (in_inst),
    .in_category     (in_category),
    .in_pc_offset    (in_pc_offset),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_category    (out_category),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_hold      (fetch_hold),
    .dbg_state       (dbg_state)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // scoreboard monitor: every accepted pop is compared with the oldest expectation
  always @(negedge clk) begin
    if (rstn && !flush && out_valid && out_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL head_unexpected: got pc 0x%08h with nothing expected", out_pc);
      end else begin
        logic [W-1:0] exp_e, act_e;
        exp_e = exp_q.pop_front();
        act_e = {out_pc, out_inst, out_category, out_pred_taken, out_pred_target};
        if (act_e === exp_e) n_pass++;
        else $display("FAIL head_entry: got %h required %h", act_e, exp_e);
      end
    end
  end

  // driver: offer one entry, wait (bounded) for acceptance, record expectation
  task automatic push_entry(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [1:0] cat, input logic [31:0] off,
                            input logic taken, input logic [31:0] target);
    int waited;
    in_pc = pc; in_inst = inst; in_category = cat; in_pc_offset = off;
    in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) break;
    end
    if (waited > 50) begin
      n_total++;
      $display("FAIL push_timeout: in_ready stayed 0 for pc 0x%08h", pc);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({pc, inst, cat, taken, target});
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_fetch_hold", 32'(fetch_hold), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(RUN));
    rstn = 1'b1;
    step();

    // fill with 8 plain entries while the decoder stalls
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      push_entry(32'h1c000000 + 32'(4*i), 32'h02800000 + 32'(i), CAT_OTHER, 32'd4,
                 1'b0, 32'h1c000004 + 32'(4*i));
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    step();
    out_ready = 1'b1;
    wait_drain("fill_drain");
    @(negedge clk);
    check("drained_out_valid", 32'(out_valid), 32'd0);
    check("drained_in_ready", 32'(in_ready), 32'd1);

    // jirl_resolved outside WAIT_JIRL has no effect
    step();
    jirl_resolved = 1'b1;
    step();
    jirl_resolved = 1'b0;
    @(negedge clk);
    check("stray_resolve_state", 32'(dbg_state), 32'(RUN));
    check("stray_resolve_hold", 32'(fetch_hold), 32'd0);
    step();

    // B: taken, redirect to pc+offset
    push_entry(32'h1c000100, 32'h50004000, CAT_JUMP, 32'h00000040, 1'b1, 32'h1c000140);
    @(negedge clk);
    check("b_redirect_valid", 32'(redirect_valid), 32'd1);
    check("b_redirect_pc", redirect_pc, 32'h1c000140);
    check("b_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("b_redirect_pulse", 32'(redirect_valid), 32'd0);
    check("b_in_ready_after", 32'(in_ready), 32'd1);
    step();

    // backward conditional: taken
    push_entry(32'h1c000200, 32'h5bfff000, CAT_COND, 32'hfffffff0, 1'b1, 32'h1c0001f0);
    @(negedge clk);
    check("bcond_redirect_valid", 32'(redirect_valid), 32'd1);
    check("bcond_redirect_pc", redirect_pc, 32'h1c0001f0);
    step();
    // forward conditional: not taken
    push_entry(32'h1c000200, 32'h58001000, CAT_COND, 32'h00000010, 1'b0, 32'h1c000204);
    @(negedge clk);
    check("fcond_no_redirect", 32'(redirect_valid), 32'd0);
    check("fcond_in_ready", 32'(in_ready), 32'd1);
    wait_drain("branch_drain");
    step();

    // JIRL hold; queue keeps draining while fetch offers a blocked entry
    out_ready = 1'b0;
    push_entry(32'h1c000300, 32'h02801000, CAT_OTHER, 32'd4, 1'b0, 32'h1c000304);
    push_entry(32'h1c000304, 32'h4c000020, CAT_JIRL, 32'd4, 1'b0, 32'h1c000308);
    in_pc = 32'h1c000308; in_inst = 32'h0badf00d; in_category = CAT_OTHER;
    in_pc_offset = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    check("jirl_hold", 32'(fetch_hold), 32'd1);
    check("jirl_in_ready", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b1;
    wait_drain("jirl_drain");
    @(negedge clk);
    check("jirl_hold_drained", 32'(fetch_hold), 32'd1);
    check("jirl_empty", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    jirl_resolved = 1'b1;
    @(negedge clk);
    check("jirl_hold_resolve_cycle", 32'(fetch_hold), 32'd1);
    step();
    jirl_resolved = 1'b0;
    @(negedge clk);
    check("jirl_hold_cleared", 32'(fetch_hold), 32'd0);
    check("jirl_in_ready_back", 32'(in_ready), 32'd1);
    step();

    // flush with 5 entries in WAIT_JIRL, push/pop/resolve in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_entry(32'h1c000400 + 32'(4*i), 32'h02802000 + 32'(i), CAT_OTHER, 32'd4,
                 1'b0, 32'h1c000404 + 32'(4*i));
    push_entry(32'h1c000410, 32'h4c000040, CAT_JIRL, 32'd4, 1'b0, 32'h1c000414);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; jirl_resolved = 1'b1;
    in_pc = 32'h1c000414;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    exp_q.delete();
    #1 flush = 1'b0; in_valid = 1'b0; jirl_resolved = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_fetch_hold", 32'(fetch_hold), 32'd0);
    check("flush_in_ready_after", 32'(in_ready), 32'd1);
    check("flush_state", 32'(dbg_state), 32'(RUN));
    step();
    push_entry(32'h1c000500, 32'h02803000, CAT_OTHER, 32'd4, 1'b0, 32'h1c000504);
    wait_drain("post_flush_drain");
    step();

    // async reset in the middle of REDIR
    out_ready = 1'b0;
    push_entry(32'h1c000600, 32'h50010000, CAT_JUMP, 32'h00000100, 1'b1, 32'h1c000700);
    #2;
    check("redir_before_reset", 32'(redirect_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("async_redirect_valid", 32'(redirect_valid), 32'd0);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_redirect_pc", redirect_pc, 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    check("post_reset_state", 32'(dbg_state), 32'(RUN));
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b1;
    push_entry(32'h1c000700, 32'h02804000, CAT_OTHER, 32'd4, 1'b0, 32'h1c000704);
    wait_drain("final_drain");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
